lock_client: RTL and testbench
==============================

// Module: lock_client
// PURPOSE
//  Accelerator-side initiator of the OmpSsManager lock protocol. Accepts lock/unlock
//  requests from the kernel, emits 64-bit commands to the lock manager, waits for the
//  8-bit ACK on lock commands, and retries with fixed backoff on reject. One per accelerator.
// PARAMETERS
//  MAX_ACCS       16  number of accelerators; ACC_BITS = $clog2(MAX_ACCS)
//  BACKOFF_CYCLES 16  cycles spent in BACKOFF between a reject and the re-send (>=1)
//  MAX_RETRIES    0   rejects tolerated before reporting failure; 0 = retry forever
// PORTS
//  clk               in   1             clock
//  rstn              in   1             reset; synchronous, active-low
//  acc_id            in   ACC_BITS      this accelerator's id; static after reset
//  req_valid         in   1             kernel request valid
//  req_ready         out  1             request accepted when valid&ready
//  req_lock          in   1             1 = lock, 0 = unlock
//  req_lock_id       in   LOCK_ID_BITS  target lock id
//  resp_valid        out  1             request completed
//  resp_ready        in   1             kernel consumes response
//  resp_ok           out  1             1 = granted/unlocked, 0 = retries exhausted
//  lock_held         out  1             a lock is currently held by this client
//  ack_err           out  1             sticky: unexpected ACK code received
//  outStream_TDATA   out  64            command word to lock manager
//  outStream_TVALID  out  1
//  outStream_TREADY  in   1
//  outStream_TID     out  ACC_BITS      = acc_id
//  inStream_TDATA    in   8             ACK code from lock manager
//  inStream_TVALID   in   1
//  inStream_TREADY   out  1
// BEHAVIOUR
//  Reset (rstn=0 at posedge): state=IDLE; resp_valid, outStream_TVALID, inStream_TREADY,
//   lock_held, ack_err, retry count = 0. Applies mid-transaction; in-flight cmd abandoned.
//  Command word: all bits 0 except [CMD_TYPE_H:CMD_TYPE_L] = CMD_LOCK_CODE/CMD_UNLOCK_CODE
//   and [LOCK_ID_H:LOCK_ID_L] = captured lock id (OmpSsManager package constants).
//  FSM (req_ready=1 only in IDLE; inStream_TREADY=1 only in WAIT_ACK):
//   IDLE: on req_valid capture req_lock, req_lock_id, clear retry count -> SEND_CMD.
//   SEND_CMD: TVALID=1, TDATA/TID stable until TREADY. On TREADY: lock -> WAIT_ACK;
//    unlock -> lock_held<=0, resp_ok<=1 -> RESPOND (manager sends no ACK for unlock).
//   WAIT_ACK: on TVALID: ACK_OK_CODE -> lock_held<=1, resp_ok<=1 -> RESPOND.
//    ACK_REJECT_CODE -> retry count +1; if MAX_RETRIES!=0 and new count==MAX_RETRIES
//    -> resp_ok<=0 -> RESPOND; else load backoff counter=BACKOFF_CYCLES -> BACKOFF.
//    Any other code -> ack_err<=1, beat consumed, remain in WAIT_ACK.
//   BACKOFF: counter decrements each cycle; exactly BACKOFF_CYCLES cycles, then SEND_CMD.
//   RESPOND: resp_valid=1, resp_ok stable until resp_ready -> IDLE.
//  Latency: req accepted cycle 0 -> TVALID cycle 1; ACK at cycle n -> resp_valid cycle n+1.
//  No outstanding overlap: one transaction at a time; new req only after response handshake.
//  Unlock while lock_held=0 is still sent; resp_ok=1. Lock while held is still sent.
//  Retry count width $clog2(MAX_RETRIES+1) (>=1); no wrap when MAX_RETRIES=0 (saturates).
//  ack_err cleared only by reset.
// TESTING
//  1 lock id 5, acc_id 3, manager ACK_OK 2 cyc after cmd -> TDATA lock/5, TID=3; resp_ok=1, lock_held=1
//  2 lock, REJECT x2 then OK, BACKOFF_CYCLES=16 -> 3 cmds, gaps of 16 BACKOFF cycles; resp_ok=1
//  3 MAX_RETRIES=2, REJECT always -> exactly 2 cmds sent; resp_ok=0, lock_held=0
//  4 unlock id 5 with TREADY low 4 cyc -> TVALID/TDATA stable 5 cyc; resp_ok=1, lock_held=0, no ACK read
//  5 ACK code 0xFF in WAIT_ACK then OK -> ack_err=1 sticky, grant still completes; resp_ready low 3 cyc holds resp
//  6 rstn low during BACKOFF and during SEND_CMD -> next cycle IDLE, TVALID=0, req_ready=1, lock_held=0

Source files
------------

// File: rtl/lock_client.sv
// Accelerator-side initiator for the OmpSsManager lock protocol: sends lock/unlock
// commands, waits for the ACK of lock commands, and retries with a fixed backoff on reject.
module lock_client #(
  parameter int MAX_ACCS       = 16,
  parameter int BACKOFF_CYCLES = 16,
  parameter int MAX_RETRIES    = 0,
  parameter int LOCK_ID_BITS   = 8,
  parameter int ACC_BITS       = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ACC_BITS-1:0]     acc_id,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_lock,
  input  logic [LOCK_ID_BITS-1:0] req_lock_id,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_ok,
  output logic                    lock_held,
  output logic                    ack_err,
  output logic [63:0]             outStream_TDATA,
  output logic                    outStream_TVALID,
  input  logic                    outStream_TREADY,
  output logic [ACC_BITS-1:0]     outStream_TID,
  input  logic [7:0]              inStream_TDATA,
  input  logic                    inStream_TVALID,
  output logic                    inStream_TREADY
);
  // OmpSsManager command / ACK encoding
  localparam int         CMD_TYPE_L      = 0;
  localparam int         CMD_TYPE_H      = 7;
  localparam int         LOCK_ID_L       = 8;
  localparam int         LOCK_ID_H       = LOCK_ID_L + LOCK_ID_BITS - 1;
  localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
  localparam logic [7:0] CMD_UNLOCK_CODE = 8'h05;
  localparam logic [7:0] ACK_OK_CODE     = 8'h01;
  localparam logic [7:0] ACK_REJECT_CODE = 8'h00;

  localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int BO_W = $clog2(BACKOFF_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_ACK, S_BACKOFF, S_RESPOND} state_t;

  state_t                  r_state, w_next;
  logic                    r_lock;
  logic [LOCK_ID_BITS-1:0] r_lock_id;
  logic [RC_W-1:0]         r_retry, w_retry_inc;
  logic [BO_W-1:0]         r_bo;
  logic                    r_resp_ok, r_held, r_err;
  logic                    w_accept, w_unlock_done, w_ack_ok, w_ack_rej, w_ack_bad, w_give_up;

  // retry count saturates instead of wrapping when retrying forever
  assign w_retry_inc = (&r_retry) ? r_retry : r_retry + RC_W'(1);

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_unlock_done = 1'b0;
    w_ack_ok      = 1'b0;
    w_ack_rej     = 1'b0;
    w_ack_bad     = 1'b0;
    w_give_up     = 1'b0;
    case (r_state)
      S_IDLE: if (req_valid) begin
        w_accept = 1'b1;
        w_next   = S_SEND;
      end
      S_SEND: if (outStream_TREADY) begin
        w_unlock_done = ~r_lock;
        w_next        = r_lock ? S_WAIT_ACK : S_RESPOND;
      end
      S_WAIT_ACK: if (inStream_TVALID) begin
        if (inStream_TDATA == ACK_OK_CODE) begin
          w_ack_ok = 1'b1;
          w_next   = S_RESPOND;
        end else if (inStream_TDATA == ACK_REJECT_CODE) begin
          w_ack_rej = 1'b1;
          w_give_up = (MAX_RETRIES != 0) && (w_retry_inc == RC_W'(MAX_RETRIES));
          w_next    = w_give_up ? S_RESPOND : S_BACKOFF;
        end else begin
          w_ack_bad = 1'b1;
        end
      end
      S_BACKOFF: if (r_bo == BO_W'(1)) w_next = S_SEND;
      S_RESPOND: if (resp_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lock    <= req_lock;
      r_lock_id <= req_lock_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_retry   <= '0;
      r_bo      <= '0;
      r_resp_ok <= 1'b0;
      r_held    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) r_retry <= '0;
      if (w_unlock_done) begin
        r_held    <= 1'b0;
        r_resp_ok <= 1'b1;
      end
      if (w_ack_ok) begin
        r_held    <= 1'b1;
        r_resp_ok <= 1'b1;
      end
      if (w_ack_rej) begin
        r_retry <= w_retry_inc;
        if (w_give_up) r_resp_ok <= 1'b0;
        else           r_bo      <= BO_W'(BACKOFF_CYCLES);
      end
      if (w_ack_bad) r_err <= 1'b1;
      if (r_state == S_BACKOFF) r_bo <= r_bo - BO_W'(1);
    end
  end

  always_comb begin
    outStream_TDATA                       = '0;
    outStream_TDATA[CMD_TYPE_H:CMD_TYPE_L] = r_lock ? CMD_LOCK_CODE : CMD_UNLOCK_CODE;
    outStream_TDATA[LOCK_ID_H:LOCK_ID_L]   = r_lock_id;
  end

  assign req_ready        = (r_state == S_IDLE);
  assign outStream_TVALID = (r_state == S_SEND);
  assign outStream_TID    = acc_id;
  assign inStream_TREADY  = (r_state == S_WAIT_ACK);
  assign resp_valid       = (r_state == S_RESPOND);
  assign resp_ok          = r_resp_ok;
  assign lock_held        = r_held;
  assign ack_err          = r_err;
endmodule

// File: tb/tb_lock_client.sv
// Bench for lock_client: directed protocol scenarios followed by randomized traffic,
// all checked every cycle against a transaction-level model of the lock client.
module tb_lock_client;
  localparam int         BO  = 16;
  localparam int         MR  = 3;
  localparam logic [7:0] OK  = 8'h01;
  localparam logic [7:0] REJ = 8'h00;

  logic        clk = 1'b0, rstn = 1'b0;
  logic [3:0]  acc_id = 4'd3;
  logic        req_valid = 1'b0, req_ready, req_lock = 1'b0;
  logic [7:0]  req_lock_id = 8'd0;
  logic        resp_valid, resp_ready = 1'b0, resp_ok, lock_held, ack_err;
  logic [63:0] outStream_TDATA;
  logic        outStream_TVALID, outStream_TREADY = 1'b0;
  logic [3:0]  outStream_TID;
  logic [7:0]  inStream_TDATA = 8'd0;
  logic        inStream_TVALID = 1'b0, inStream_TREADY;

  lock_client #(.MAX_ACCS(16), .BACKOFF_CYCLES(BO), .MAX_RETRIES(MR), .LOCK_ID_BITS(8)) dut (
    .clk(clk), .rstn(rstn), .acc_id(acc_id),
    .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock), .req_lock_id(req_lock_id),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ok(resp_ok),
    .lock_held(lock_held), .ack_err(ack_err),
    .outStream_TDATA(outStream_TDATA), .outStream_TVALID(outStream_TVALID),
    .outStream_TREADY(outStream_TREADY), .outStream_TID(outStream_TID),
    .inStream_TDATA(inStream_TDATA), .inStream_TVALID(inStream_TVALID),
    .inStream_TREADY(inStream_TREADY)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, hs_cnt = 0;
  bit done = 1'b0;

  // Transaction-level model: which step of a request is outstanding
  localparam int M_IDLE = 0, M_CMD = 1, M_ACK = 2, M_BACK = 3, M_RESP = 4;
  int         m_ph = M_IDLE, m_rej = 0, m_left = 0;
  bit         m_lock = 1'b0, m_ok = 1'b0, m_held = 1'b0, m_err = 1'b0;
  logic [7:0] m_id = 8'd0;

  always @(posedge clk) begin
    if (!rstn) begin
      m_ph <= M_IDLE; m_held <= 1'b0; m_err <= 1'b0; m_rej <= 0;
    end else begin
      case (m_ph)
        M_IDLE: if (req_valid) begin
          m_lock <= req_lock; m_id <= req_lock_id; m_rej <= 0; m_ph <= M_CMD;
        end
        M_CMD: if (outStream_TREADY) begin
          if (m_lock) m_ph <= M_ACK;
          else begin m_held <= 1'b0; m_ok <= 1'b1; m_ph <= M_RESP; end
        end
        M_ACK: if (inStream_TVALID) begin
          if (inStream_TDATA == OK) begin
            m_held <= 1'b1; m_ok <= 1'b1; m_ph <= M_RESP;
          end else if (inStream_TDATA == REJ) begin
            m_rej <= m_rej + 1;
            if (m_rej + 1 == MR) begin m_ok <= 1'b0; m_ph <= M_RESP; end
            else begin m_left <= BO; m_ph <= M_BACK; end
          end else m_err <= 1'b1;
        end
        M_BACK: if (m_left == 1) m_ph <= M_CMD; else m_left <= m_left - 1;
        M_RESP: if (resp_ready) m_ph <= M_IDLE;
        default: m_ph <= M_IDLE;
      endcase
    end
  end

  always @(posedge clk)
    if (rstn && outStream_TVALID && outStream_TREADY) hs_cnt <= hs_cnt + 1;

  function automatic logic [63:0] cmd_word(input bit l, input logic [7:0] id);
    return (64'(id) << 8) | (l ? 64'h04 : 64'h05);
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin n_err++; $display("FAIL %s: got %0b expected %0b", nm, act, exp); end
  endtask

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin n_err++; $display("FAIL %s: got %h expected %h", nm, act, exp); end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin n_err++; $display("FAIL %s: got %0d expected %0d", nm, act, exp); end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_req(input bit l, input logic [7:0] id);
    req_valid = 1'b1; req_lock = l; req_lock_id = id;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic cmd_hs();
    outStream_TREADY = 1'b1; tick(); outStream_TREADY = 1'b0;
  endtask

  task automatic ack(input logic [7:0] code);
    inStream_TVALID = 1'b1; inStream_TDATA = code; tick(); inStream_TVALID = 1'b0;
  endtask

  task automatic take_resp();
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!(outStream_TVALID || resp_valid) && cyc < BO + 8) begin tick(); cyc++; end
    if (!(outStream_TVALID || resp_valid)) chki("wait_timeout", cyc, -1);
  endtask

  // Serve a lock request: reject the first n_rej commands (or all of them), then grant
  task automatic drive_lock(input bit rej_forever, input int n_rej);
    int  k = 0, cyc = 0, g = 0;
    bit  fin = 1'b0;
    while (!fin && g < 10) begin
      wait_out(cyc);
      if (resp_valid) fin = 1'b1;
      else begin
        if (k > 0) chki("backoff_gap", cyc, BO);
        cmd_hs();
        ack((rej_forever || k < n_rej) ? REJ : OK);
        k++;
      end
      g++;
    end
  endtask

  initial begin
    fork
      begin
        while (!done) begin
          @(negedge clk);
          chk1("req_ready", req_ready, m_ph == M_IDLE);
          chk1("out_tvalid", outStream_TVALID, m_ph == M_CMD);
          chk1("in_tready", inStream_TREADY, m_ph == M_ACK);
          chk1("resp_valid", resp_valid, m_ph == M_RESP);
          chk1("lock_held", lock_held, m_held);
          chk1("ack_err", ack_err, m_err);
          if (m_ph == M_CMD) begin
            chk64("out_tdata", outStream_TDATA, cmd_word(m_lock, m_id));
            chk64("out_tid", 64'(outStream_TID), 64'(acc_id));
          end
          if (m_ph == M_RESP) chk1("resp_ok", resp_ok, m_ok);
        end
      end
      begin
        int h0, stable;
        repeat (3) tick();
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_tvalid", outStream_TVALID, 1'b0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_in_tready", inStream_TREADY, 1'b0);
        chk1("rst_ack_err", ack_err, 1'b0);
        rstn = 1'b1;
        tick();

        // 1: plain grant, ACK two cycles after the command
        send_req(1'b1, 8'd5);
        chk1("t1_tvalid", outStream_TVALID, 1'b1);
        chk64("t1_tdata", outStream_TDATA, 64'h0000_0000_0000_0504);
        chk64("t1_tid", 64'(outStream_TID), 64'd3);
        cmd_hs();
        tick();
        ack(OK);
        chk1("t1_resp_valid", resp_valid, 1'b1);
        chk1("t1_resp_ok", resp_ok, 1'b1);
        chk1("t1_lock_held", lock_held, 1'b1);
        take_resp();
        chk1("t1_idle", req_ready, 1'b1);

        // 2: two rejects then grant
        h0 = hs_cnt;
        send_req(1'b1, 8'd9);
        drive_lock(1'b0, 2);
        chki("t2_cmds", hs_cnt - h0, 3);
        chk1("t2_resp_ok", resp_ok, 1'b1);
        take_resp();

        // 4: unlock with a stalled stream; a pending ACK beat must be ignored
        send_req(1'b0, 8'd5);
        inStream_TVALID = 1'b1; inStream_TDATA = OK;
        stable = 0;
        for (int i = 0; i < 4; i++) begin
          if (outStream_TVALID && outStream_TDATA == 64'h505) stable++;
          chk1("t4_no_ack_read", inStream_TREADY, 1'b0);
          tick();
        end
        outStream_TREADY = 1'b1;
        if (outStream_TVALID && outStream_TDATA == 64'h505) stable++;
        tick();
        outStream_TREADY = 1'b0; inStream_TVALID = 1'b0;
        chki("t4_stable_cycles", stable, 5);
        chk1("t4_resp_ok", resp_ok, 1'b1);
        chk1("t4_lock_held", lock_held, 1'b0);
        take_resp();

        // 3: rejected until the retry limit
        h0 = hs_cnt;
        send_req(1'b1, 8'd6);
        drive_lock(1'b1, 0);
        chki("t3_cmds", hs_cnt - h0, MR);
        chk1("t3_resp_valid", resp_valid, 1'b1);
        chk1("t3_resp_ok", resp_ok, 1'b0);
        chk1("t3_lock_held", lock_held, 1'b0);
        take_resp();

        // 5: bad ACK code, then grant; response held while resp_ready low
        send_req(1'b1, 8'd7);
        cmd_hs();
        ack(8'hFF);
        chk1("t5_ack_err", ack_err, 1'b1);
        chk1("t5_still_waiting", inStream_TREADY, 1'b1);
        ack(OK);
        for (int i = 0; i < 3; i++) begin
          chk1("t5_resp_hold", resp_valid, 1'b1);
          chk1("t5_resp_ok", resp_ok, 1'b1);
          tick();
        end
        take_resp();
        chk1("t5_ack_err_sticky", ack_err, 1'b1);
        chk1("t5_lock_held", lock_held, 1'b1);

        // 6: reset during backoff, then during command send
        send_req(1'b1, 8'd2);
        cmd_hs();
        ack(REJ);
        tick(); tick();
        rstn = 1'b0; tick(); rstn = 1'b1;
        chk1("t6a_tvalid", outStream_TVALID, 1'b0);
        chk1("t6a_req_ready", req_ready, 1'b1);
        chk1("t6a_lock_held", lock_held, 1'b0);
        chk1("t6a_ack_err", ack_err, 1'b0);
        send_req(1'b1, 8'd4);
        chk1("t6b_tvalid_before", outStream_TVALID, 1'b1);
        rstn = 1'b0; tick(); rstn = 1'b1;
        chk1("t6b_tvalid", outStream_TVALID, 1'b0);
        chk1("t6b_req_ready", req_ready, 1'b1);

        // randomized traffic, checked by the per-cycle compare
        for (int c = 0; c < 4000; c++) begin
          int r;
          rstn             = ($urandom_range(0, 299) != 0);
          req_valid        = $urandom_range(0, 1) != 0;
          req_lock         = $urandom_range(0, 2) != 0;
          req_lock_id      = 8'($urandom_range(0, 255));
          resp_ready       = $urandom_range(0, 1) != 0;
          outStream_TREADY = $urandom_range(0, 1) != 0;
          inStream_TVALID  = $urandom_range(0, 4) < 2;
          r = $urandom_range(0, 19);
          inStream_TDATA   = (r < 10) ? OK : (r < 17) ? REJ : 8'($urandom_range(2, 255));
          tick();
        end
        rstn = 1'b1;
        done = 1'b1;
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
